display_scanner: RTL and testbench

DISPLAY_SCANNER -- requirements
Module: display_scanner

---
 rtl/display_scanner.sv | 94 +++++++++
 tb/tb_display_scanner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/display_scanner.sv
// Two-digit multiplexed 7-segment scanner with a one-cycle blank on every digit switch.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module display_scanner #(
  parameter int unsigned REFRESH_DIV = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] ten_count,
  input  logic [3:0] unit_count,
  output logic [6:0] segments,
  output logic       digit
);

  typedef enum logic {SCAN_UNITS = 1'b0, SCAN_TENS = 1'b1} state_e;

  localparam logic [15:0] CNT_MAX = 16'(REFRESH_DIV - 1);

  // Reset asserts asynchronously but releases only after two clean edges.
  logic rs1_q, rs2_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs1_q <= 1'b0;
      rs2_q <= 1'b0;
    end else begin
      rs1_q <= 1'b1;
      rs2_q <= rs1_q;
    end
  end

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  tens_q, tens_d, units_q, units_d;
  logic        shown_q, shown_d;
  logic [6:0]  seg_q, seg_d;
  logic        wrap;
  logic [3:0]  sel;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  always_comb begin
    wrap    = (cnt_q == CNT_MAX);
    cnt_d   = wrap ? 16'd0 : cnt_q + 16'd1;
    state_d = state_q;
    if (wrap) state_d = (state_q == SCAN_UNITS) ? SCAN_TENS : SCAN_UNITS;
    tens_d  = load ? ten_count  : tens_q;
    units_d = load ? unit_count : units_q;
    shown_d = shown_q | load;
    // Display path uses the registers as they stood before this edge,
    // giving the one-cycle load-to-segment latency.
    sel     = (state_q == SCAN_TENS) ? tens_q : units_q;
    seg_d   = decode(sel);
`ifdef LEADING_ZERO_BLANK_EN
    if (state_q == SCAN_TENS && tens_q == 4'd0) seg_d = 7'h00;
`endif
    if (wrap || !shown_q) seg_d = 7'h00;
  end

  always_ff @(posedge clk or negedge rs2_q) begin
    if (!rs2_q) begin
      state_q <= SCAN_UNITS;
      cnt_q   <= 16'd0;
      tens_q  <= 4'd0;
      units_q <= 4'd0;
      shown_q <= 1'b0;
      seg_q   <= 7'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      shown_q <= shown_d;
      seg_q   <= seg_d;
    end
  end

  assign segments = seg_q;
  assign digit    = (state_q == SCAN_TENS);

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench: two scanners (REFRESH_DIV 100 and 2) against a cycle-count reference model.
module tb_display_scanner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load;
  logic [3:0] ten_count, unit_count;
  logic [6:0] seg_a, seg_b;
  logic       dig_a, dig_b;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  display_scanner #(.REFRESH_DIV(100)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .ten_count(ten_count),
    .unit_count(unit_count), .segments(seg_a), .digit(dig_a));

  display_scanner #(.REFRESH_DIV(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .load(load), .ten_count(ten_count),
    .unit_count(unit_count), .segments(seg_b), .digit(dig_b));

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic [6:0] dec_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int         divs [0:1] = '{100, 2};

  function automatic logic [6:0] ref_dec(input logic [3:0] v, input bit is_tens);
    if (v > 4'd9) return 7'h40;
    if (is_tens && LZB && v == 4'd0) return 7'h00;
    return dec_tab[v];
  endfunction

  // Reference model: t counts active edges since the internal reset release;
  // the digit shown is (t / DIV) mod 2 and every multiple of DIV is a blank cycle.
  int         m_sync, m_t;
  logic [3:0] m_tens, m_units;
  bit         m_shown;
  logic [6:0] exp_seg [0:1];
  bit         exp_dig [0:1];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_sync = 0; m_t = 0; m_tens = 0; m_units = 0; m_shown = 0;
      for (int k = 0; k < 2; k++) begin exp_seg[k] = 7'h00; exp_dig[k] = 1'b0; end
    end else if (m_sync < 2) begin
      m_sync++;
    end else begin
      m_t++;
      for (int k = 0; k < 2; k++) begin
        bit d;
        d = ((m_t / divs[k]) % 2) == 1;
        exp_dig[k] = d;
        if ((m_t % divs[k]) == 0 || !m_shown) exp_seg[k] = 7'h00;
        else exp_seg[k] = ref_dec(d ? m_tens : m_units, d);
      end
      if (load) begin m_tens = ten_count; m_units = unit_count; m_shown = 1; end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      if (errors < 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("seg_div100", seg_a, exp_seg[0]);
      check("dig_div100", dig_a, exp_dig[0]);
      check("seg_div2",   seg_b, exp_seg[1]);
      check("dig_div2",   dig_b, exp_dig[1]);
    end
  end

  typedef struct {
    logic [3:0] tens;
    logic [3:0] units;
    logic [6:0] exp_u;
    logic [6:0] exp_t;
  } vec_t;

  vec_t vecs [6];

  // Waits until dut has shown digit d on two consecutive samples (past the blank).
  task automatic wait_phase(input bit d, output bit ok);
    bit prev;
    prev = ~d;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (dig_a == d && prev == d) begin ok = 1'b1; break; end
      prev = dig_a;
    end
  endtask

  initial begin
    bit ok, prev;
    int tog_a, tog_b;
    bit pa, pb;

    vecs[0] = '{4'd2,  4'd3,  7'h4F, 7'h5B};
    vecs[1] = '{4'd12, 4'd5,  7'h6D, 7'h40};
    vecs[2] = '{4'd0,  4'd7,  7'h07, LZB ? 7'h00 : 7'h3F};
    vecs[3] = '{4'd9,  4'd8,  7'h7F, 7'h6F};
    vecs[4] = '{4'd15, 4'd10, 7'h40, 7'h40};
    vecs[5] = '{4'd1,  4'd0,  7'h3F, 7'h06};

    reset_n = 1'b0; load = 1'b0; ten_count = 4'd0; unit_count = 4'd0;
    #1;
    check("reset_seg", seg_a, 7'h00);
    check("reset_dig", dig_a, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // No load: blank throughout, digit toggles on every REFRESH_DIV-th active edge.
    tog_a = 0; tog_b = 0; pa = dig_a; pb = dig_b;
    repeat (305) begin
      @(negedge clk);
      if (dig_a != pa) tog_a++;
      if (dig_b != pb) tog_b++;
      pa = dig_a; pb = dig_b;
    end
    check("toggles_div100", tog_a, 3);
    check("toggles_div2", tog_b, 151);

    foreach (vecs[i]) begin
      @(negedge clk);
      load = 1'b1; ten_count = vecs[i].tens; unit_count = vecs[i].units;
      @(negedge clk);
      load = 1'b0;
      wait_phase(1'b0, ok);
      check("units_phase_reached", ok, 1);
      check("vec_units", seg_a, vecs[i].exp_u);
      wait_phase(1'b1, ok);
      check("tens_phase_reached", ok, 1);
      check("vec_tens", seg_a, vecs[i].exp_t);
    end

    // Load on the wrap edge into SCAN_TENS, then reset mid-tens.
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (((m_t + 1) % 100) == 0 && (((m_t + 1) / 100) % 2) == 1) begin ok = 1'b1; break; end
    end
    check("wrap_edge_found", ok, 1);
    load = 1'b1; ten_count = 4'd6; unit_count = 4'd1;
    @(negedge clk);
    load = 1'b0;
    check("wrap_guard", seg_a, 7'h00);
    check("wrap_digit", dig_a, 1);
    @(negedge clk);
    check("wrap_captured", seg_a, 7'h7D);
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_seg", seg_a, 7'h00);
    check("async_dig", dig_a, 0);
    check("async_seg2", seg_b, 7'h00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tog_a = 0; pa = dig_a; prev = 1'b0;
    repeat (250) begin
      @(negedge clk);
      if (seg_a != 7'h00) prev = 1'b1;
      if (dig_a != pa) tog_a++;
      pa = dig_a;
    end
    check("blank_after_reset", prev, 0);
    check("toggles_after_reset", tog_a, 2);

    // Random loads, including back-to-back, checked every cycle by the model.
    repeat (3000) begin
      @(negedge clk);
      load = ($urandom_range(0, 3) == 0);
      ten_count = 4'($urandom_range(0, 15));
      unit_count = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
